// File: rtl/axis_pkt_rx.sv
// rtl/axis_pkt_rx.sv - store-and-forward AXI4-Stream packet receiver with descriptor and random-access buffer
// One packet is buffered at a time; the buffer is held until the descriptor is released.
module axis_pkt_rx #(
  parameter int N     = 4,
  parameter int DEPTH = 256,
  parameter int I     = 1,
  parameter int D     = 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int BW   = $clog2(DEPTH*N+1)
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           s_tvalid,
  output logic           s_tready,
  input  logic [8*N-1:0] s_tdata,
  input  logic [N-1:0]   s_tkeep,
  input  logic           s_tlast,
  input  logic [I-1:0]   s_tid,
  input  logic [D-1:0]   s_tdest,
  output logic           desc_valid,
  input  logic           desc_ready,
  output logic [AW:0]    desc_beats,
  output logic [BW-1:0]  desc_bytes,
  output logic [I-1:0]   desc_tid,
  output logic [D-1:0]   desc_tdest,
  output logic [1:0]     desc_err,
  input  logic [AW-1:0]  rd_addr,
  output logic [8*N-1:0] rd_data,
  output logic [N-1:0]   rd_keep
);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2, HOLD = 2'd3} state_t;

  state_t          state, nxt;
  logic            acc, full, mism, wr_en, tready_d;
  logic [AW-1:0]   wa;
  logic [BW-1:0]   kcnt;
  logic [8*N-1:0]  mem_d [DEPTH];
  logic [N-1:0]    mem_k [DEPTH];

  function automatic logic [BW-1:0] popcnt(input logic [N-1:0] k);
    logic [BW-1:0] c;
    c = '0;
    for (int j = 0; j < N; j++) c = c + BW'(k[j]);
    return c;
  endfunction

  assign acc  = s_tvalid & s_tready;
  assign full = (desc_beats == (AW+1)'(DEPTH));
  assign mism = (s_tid != desc_tid) || (s_tdest != desc_tdest);
  assign kcnt = popcnt(s_tkeep);

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (acc) nxt = s_tlast ? HOLD : RECV;
      RECV: if (acc) begin
              if (s_tlast)   nxt = HOLD;
              else if (full) nxt = DROP;
            end
      DROP: if (acc && s_tlast) nxt = HOLD;
      HOLD: if (desc_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    desc_valid = (state == HOLD);
    tready_d   = (nxt != HOLD);
    wr_en      = acc && ((state == IDLE) || ((state == RECV) && !full));
    wa         = (state == IDLE) ? '0 : desc_beats[AW-1:0];
  end

  // Counters and error flags follow the state the beat arrives in.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_tready   <= 1'b0;
      desc_beats <= '0;
      desc_bytes <= '0;
      desc_tid   <= '0;
      desc_tdest <= '0;
      desc_err   <= '0;
    end else begin
      s_tready <= tready_d;
      case (state)
        IDLE: if (acc) begin
                desc_beats <= (AW+1)'(1);
                desc_bytes <= kcnt;
                desc_tid   <= s_tid;
                desc_tdest <= s_tdest;
                desc_err   <= '0;
              end
        RECV: if (acc) begin
                if (full) begin
                  desc_err[0] <= 1'b1;
                end else begin
                  desc_beats <= desc_beats + (AW+1)'(1);
                  desc_bytes <= desc_bytes + kcnt;
                  if (mism) desc_err[1] <= 1'b1;
                end
              end
        HOLD: if (desc_ready) begin
                desc_beats <= '0;
                desc_bytes <= '0;
                desc_err   <= '0;
              end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_d[wa] <= s_tdata;
      mem_k[wa] <= s_tkeep;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_data <= '0;
      rd_keep <= '0;
    end else begin
      rd_data <= mem_d[rd_addr];
      rd_keep <= mem_k[rd_addr];
    end
  end

endmodule

// File: tb/tb_axis_pkt_rx.sv
// tb/tb_axis_pkt_rx.sv - randomized self-checking bench for axis_pkt_rx
// Expected descriptors are computed from whole-packet beat lists.
module tb_axis_pkt_rx;

  localparam int N = 4;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic [1:0]  id;
    logic [1:0]  de;
  } beat_t;

  typedef struct {
    int         beats;
    int         bytes;
    logic [1:0] id;
    logic [1:0] de;
    logic [1:0] err;
  } desc_t;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        s_tvalid, s_tready, s_tlast;
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep;
  logic [1:0]  s_tid, s_tdest;
  logic        desc_valid, desc_ready;
  logic [3:0]  desc_beats;
  logic [5:0]  desc_bytes;
  logic [1:0]  desc_tid, desc_tdest, desc_err;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  rd_keep;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int first_acc = 0;
  int last_acc = 0;
  bit seen = 1'b0;
  beat_t pkt[$];
  desc_t expq[$];
  desc_t last_exp;

  axis_pkt_rx #(.N(N), .DEPTH(DEPTH), .I(2), .D(2)) dut (
    .aclk(clk), .aresetn(aresetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_beats(desc_beats),
    .desc_bytes(desc_bytes), .desc_tid(desc_tid), .desc_tdest(desc_tdest), .desc_err(desc_err),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_keep(rd_keep)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic desc_t model_pkt();
    desc_t e;
    int n, s;
    n = pkt.size();
    s = (n > DEPTH) ? DEPTH : n;
    e.beats = s;
    e.bytes = 0;
    for (int i = 0; i < s; i++) e.bytes += $countones(pkt[i].k);
    e.id  = pkt[0].id;
    e.de  = pkt[0].de;
    e.err = 2'b00;
    e.err[0] = (n > DEPTH);
    for (int i = 1; i < s; i++)
      if (pkt[i].id != pkt[0].id || pkt[i].de != pkt[0].de) e.err[1] = 1'b1;
    return e;
  endfunction

  // Descriptor scoreboard: checked once per HOLD entry.
  always @(negedge clk) begin
    if (aresetn && desc_valid && !seen) begin
      seen = 1'b1;
      if (expq.size() == 0) begin
        chk("unexpected_desc", 1, 0);
      end else begin
        last_exp = expq.pop_front();
        chk("desc_beats", desc_beats, last_exp.beats);
        chk("desc_bytes", desc_bytes, last_exp.bytes);
        chk("desc_tid",   desc_tid,   last_exp.id);
        chk("desc_tdest", desc_tdest, last_exp.de);
        chk("desc_err",   desc_err,   last_exp.err);
      end
    end
    if (!desc_valid) seen = 1'b0;
  end

  task automatic mk_pkt(input int n, input bit chg);
    beat_t b;
    logic [1:0] id0, de0;
    id0 = 2'($urandom);
    de0 = 2'($urandom);
    pkt.delete();
    for (int i = 0; i < n; i++) begin
      b.d  = $urandom;
      b.k  = 4'($urandom);
      b.l  = (i == n-1);
      b.id = id0;
      b.de = de0;
      if (chg && i == n-1 && i > 0) b.id = id0 ^ 2'd1;
      pkt.push_back(b);
    end
  endtask

  task automatic drive_beat(input beat_t b);
    s_tdata = b.d;
    s_tkeep = b.k;
    s_tlast = b.l;
    s_tid   = b.id;
    s_tdest = b.de;
  endtask

  task automatic send(input int pvalid, input bit rel_first, input bit keep_valid);
    int idx, guard;
    bit acc;
    idx = 0;
    guard = 0;
    while (idx < pkt.size() && guard < 4000) begin
      @(negedge clk);
      if (rel_first && idx > 0) desc_ready = 1'b0;
      s_tvalid = ($urandom_range(99) < pvalid);
      drive_beat(pkt[idx]);
      if (s_tvalid && !s_tready) stall_cnt++;
      acc = s_tvalid && s_tready;
      if (acc) begin
        if (idx == 0) first_acc = cyc;
        last_acc = cyc;
      end
      @(posedge clk);
      if (acc) begin
        if (pkt[idx].l) expq.push_back(model_pkt());
        idx++;
      end
      guard++;
    end
    @(negedge clk);
    if (idx < pkt.size()) begin
      chk("send_timeout", idx, pkt.size());
    end else if (pkt[pkt.size()-1].l) begin
      chk("tready_after_last", s_tready, 0);
      chk("valid_after_last", desc_valid, 1);
    end
    if (!keep_valid) s_tvalid = 1'b0;
  endtask

  task automatic rd_check();
    int s;
    s = (pkt.size() > DEPTH) ? DEPTH : pkt.size();
    for (int i = 0; i < s; i++) begin
      @(negedge clk);
      rd_addr = 3'(i);
      @(negedge clk);
      chk($sformatf("rd_data[%0d]", i), rd_data, pkt[i].d);
      chk($sformatf("rd_keep[%0d]", i), rd_keep, pkt[i].k);
    end
  endtask

  task automatic release_desc();
    @(negedge clk);
    desc_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", desc_valid, 0);
    chk("release_tready", s_tready, 1);
    desc_ready = 1'b0;
  endtask

  initial begin
    beat_t b;
    int gap, hold_bad;
    aresetn = 1'b0; s_tvalid = 1'b0; desc_ready = 1'b0; rd_addr = '0;
    s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tid = '0; s_tdest = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", s_tready, 0);
    chk("rst_valid", desc_valid, 0);
    chk("rst_beats", desc_beats, 0);
    chk("rst_bytes", desc_bytes, 0);
    chk("rst_err", desc_err, 0);
    chk("rst_tid", desc_tid, 0);
    chk("rst_tdest", desc_tdest, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_keep", rd_keep, 0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("tready_rise", s_tready, 1);

    // single-beat packet
    pkt.delete();
    b.d = 32'hA5A5A5A5; b.k = 4'h7; b.l = 1'b1; b.id = 2'd1; b.de = 2'd0;
    pkt.push_back(b);
    send(100, 1'b0, 1'b0);
    rd_check();
    release_desc();

    // 5-beat packet with random tvalid, then back-to-back packet
    desc_ready = 1'b1;
    pkt.delete();
    for (int i = 0; i < 5; i++) begin
      b.d = $urandom; b.k = (i == 4) ? 4'h1 : 4'hF; b.l = (i == 4); b.id = 2'd2; b.de = 2'd1;
      pkt.push_back(b);
    end
    send(60, 1'b0, 1'b1);
    gap = last_acc;
    mk_pkt(3, 1'b0);
    send(100, 1'b1, 1'b0);
    chk("b2b_turnaround", first_acc - gap, 2);
    rd_check();
    release_desc();

    // overflow
    stall_cnt = 0;
    mk_pkt(11, 1'b0);
    send(100, 1'b0, 1'b0);
    chk("ovf_tready_stalls", stall_cnt, 0);
    rd_check();
    release_desc();

    // tid change mid-packet
    pkt.delete();
    for (int i = 0; i < 3; i++) begin
      b.d = $urandom; b.k = 4'hF; b.l = (i == 2); b.id = (i == 2) ? 2'd1 : 2'd0; b.de = 2'd0;
      pkt.push_back(b);
    end
    send(100, 1'b0, 1'b0);
    release_desc();

    // hold for 20 cycles under tvalid, then release with a beat waiting
    mk_pkt(2, 1'b0);
    send(100, 1'b0, 1'b0);
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata = $urandom;
      if (s_tready !== 1'b0 || desc_valid !== 1'b1 || desc_beats != last_exp.beats ||
          desc_bytes != last_exp.bytes || desc_tid != last_exp.id ||
          desc_tdest != last_exp.de || desc_err != last_exp.err) hold_bad++;
    end
    chk("hold_stable", hold_bad, 0);
    mk_pkt(1, 1'b0);
    @(negedge clk);
    desc_ready = 1'b1;
    s_tvalid = 1'b1;
    drive_beat(pkt[0]);
    @(negedge clk);
    chk("pulse_valid", desc_valid, 0);
    chk("pulse_tready", s_tready, 1);
    desc_ready = 1'b0;
    expq.push_back(model_pkt());
    @(negedge clk);
    chk("pulse_next_accept", desc_valid, 1);
    s_tvalid = 1'b0;
    rd_check();
    release_desc();

    // reset mid-packet
    mk_pkt(6, 1'b0);
    while (pkt.size() > 3) void'(pkt.pop_back());
    send(100, 1'b0, 1'b0);
    aresetn = 1'b0;
    @(negedge clk);
    chk("midrst_tready", s_tready, 0);
    chk("midrst_valid", desc_valid, 0);
    chk("midrst_beats", desc_beats, 0);
    aresetn = 1'b1;
    mk_pkt(2, 1'b0);
    send(100, 1'b0, 1'b0);
    rd_check();
    release_desc();

    // random packets
    for (int p = 0; p < 15; p++) begin
      mk_pkt($urandom_range(1, 11), 1'($urandom_range(1)));
      send($urandom_range(40, 100), 1'b0, 1'b0);
      rd_check();
      release_desc();
    end

    repeat (3) @(negedge clk);
    chk("expq_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
